// File: rtl/riscv_lite_pkg.sv
// Opcodes, decoded-control struct and immediate/ALU helpers shared by the riscv_lite core.
// Latency: pure combinational helpers; backpressure: none.
package riscv_lite_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

    typedef struct packed {
        logic      reg_we;
        logic      mem_we;
        logic      a_pc;
        logic      b_imm;
        logic      branch;
        logic      jal;
        logic      jalr;
        alu_op_e   alu_op;
        imm_type_e imm_type;
        wb_sel_e   wb_sel;
    } ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_e kind);
        logic [31:0] imm;
        case (kind)
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = {{20{inst[31]}}, inst[31:20]};
        endcase
        return imm;
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_SUB:   r = a - b;
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_SLT:   r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  r = {31'b0, a < b};
            ALU_SLL:   r = a << b[4:0];
            ALU_SRL:   r = a >> b[4:0];
            ALU_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
            ALU_PASSB: r = b;
            default:   r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_lite_mem.sv
// Word memories for the core: a generic cell plus instruction and banked data wrappers.
// Latency: combinational read, write on the rising edge; backpressure: none.
module riscv_lite_mem_cell #(
    parameter int WORDS = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [WORDS];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

module riscv_lite_imem #(
    parameter logic [31:0] BASE  = 32'h0040_0000,
    parameter int          WORDS = 1024
) (
    input  logic        clk,
    input  logic [31:0] addr,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] widx;
    logic [31:0] cell_rdata;
    logic        hit;

    assign widx = (addr - BASE) >> 2;
    assign hit  = widx < 32'(WORDS);

    for (genvar g = 0; g < 1; g++) begin : CELL
        riscv_lite_mem_cell #(.WORDS(WORDS)) CELL (
            .clk(clk), .we(1'b0), .addr(widx[AW-1:0]), .wdata(32'h0), .rdata(cell_rdata)
        );
    end

    // Fetches outside the array decode as ADDI x0,x0,0 so the core keeps running.
    assign rdata = hit ? cell_rdata : 32'h0000_0013;
endmodule

module riscv_lite_dmem #(
    parameter logic [31:0] BASE  = 32'h1001_0000,
    parameter int          WORDS = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int HALF = WORDS / 2;
    localparam int HW   = $clog2(HALF);

    logic [31:0] widx;
    logic [31:0] rdata0, rdata1;
    logic        hit, upper;

    assign widx  = (addr - BASE) >> 2;
    assign hit   = widx < 32'(WORDS);
    assign upper = widx >= 32'(HALF);

    riscv_lite_mem_cell #(.WORDS(HALF)) CELL_0 (
        .clk(clk), .we(we & hit & ~upper), .addr(widx[HW-1:0]), .wdata(wdata), .rdata(rdata0)
    );

    riscv_lite_mem_cell #(.WORDS(HALF)) CELL_1 (
        .clk(clk), .we(we & hit & upper), .addr(widx[HW-1:0]), .wdata(wdata), .rdata(rdata1)
    );

    assign rdata = !hit ? 32'h0 : (upper ? rdata1 : rdata0);
endmodule

// File: rtl/riscv_lite_regfile.sv
// 32x32 register file, x0 hardwired to zero, two async read ports and one write port.
// Latency: combinational read, write on the rising edge; backpressure: none.
module riscv_lite_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] registers [32];

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : registers[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : registers[raddr2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'h0;
        end else if (we && waddr != 5'd0) begin
            registers[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/riscv_lite_cpu.sv
// Single-cycle RV32I-subset core with private instruction and data memories.
// Latency: one instruction retires per clock; backpressure: none, never stalls.
module riscv_lite_cpu
    import riscv_lite_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] DMEM_BASE  = 32'h1001_0000
) (
    input logic clk_i,
    input logic rst_i
);
    logic [31:0] inst_addr, next_pc, pc_plus4, inst, imm;
    logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_res, dmem_rdata, wb_data;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        r_ok, i_ok, alt, br_taken;
    alu_op_e     f3_op;
    ctrl_t       ctrl;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    riscv_lite_imem #(.BASE(RESET_PC), .WORDS(IMEM_WORDS)) INST_MEM (
        .clk(clk_i), .addr(inst_addr), .rdata(inst)
    );

    // Only the exact funct7 encodings RV32I defines are accepted; anything else is a NOP.
    assign r_ok = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
    assign i_ok = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                  (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
    assign alt  = funct7[5] & ((opcode == OP_REG) || (funct3 == 3'b101));

    always_comb begin
        f3_op = ALU_AND;
        case (funct3)
            3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b011:  f3_op = ALU_SLTU;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_REG:    if (r_ok) begin ctrl.reg_we = 1'b1; ctrl.alu_op = f3_op; end
            OP_IMM:    if (i_ok) begin ctrl.reg_we = 1'b1; ctrl.b_imm = 1'b1; ctrl.alu_op = f3_op; end
            OP_LOAD:   if (funct3 == 3'b010) begin
                           ctrl.reg_we = 1'b1; ctrl.b_imm = 1'b1; ctrl.wb_sel = WB_MEM;
                       end
            OP_STORE:  if (funct3 == 3'b010) begin
                           ctrl.mem_we = 1'b1; ctrl.b_imm = 1'b1; ctrl.imm_type = IMM_S;
                       end
            OP_LUI:    begin
                           ctrl.reg_we = 1'b1; ctrl.b_imm = 1'b1; ctrl.imm_type = IMM_U;
                           ctrl.alu_op = ALU_PASSB;
                       end
            OP_AUIPC:  begin
                           ctrl.reg_we = 1'b1; ctrl.a_pc = 1'b1; ctrl.b_imm = 1'b1;
                           ctrl.imm_type = IMM_U;
                       end
            OP_JAL:    begin
                           ctrl.reg_we = 1'b1; ctrl.jal = 1'b1; ctrl.imm_type = IMM_J;
                           ctrl.wb_sel = WB_PC4;
                       end
            OP_JALR:   if (funct3 == 3'b000) begin
                           ctrl.reg_we = 1'b1; ctrl.jalr = 1'b1; ctrl.b_imm = 1'b1;
                           ctrl.wb_sel = WB_PC4;
                       end
            OP_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) begin
                           ctrl.branch = 1'b1; ctrl.imm_type = IMM_B;
                       end
            default:   ctrl = '0;
        endcase
    end

    riscv_lite_regfile Registers (
        .clk(clk_i), .rst(rst_i), .raddr1(rs1), .raddr2(rs2),
        .we(ctrl.reg_we), .waddr(rd), .wdata(wb_data),
        .rdata1(rs1_val), .rdata2(rs2_val)
    );

    assign imm     = imm_gen(inst, ctrl.imm_type);
    assign alu_a   = ctrl.a_pc ? inst_addr : rs1_val;
    assign alu_b   = ctrl.b_imm ? imm : rs2_val;
    assign alu_res = alu(ctrl.alu_op, alu_a, alu_b);

    // Stores are suppressed in reset so preloaded data survives the reset window.
    riscv_lite_dmem #(.BASE(DMEM_BASE), .WORDS(DMEM_WORDS)) DATA_MEM (
        .clk(clk_i), .we(ctrl.mem_we & ~rst_i), .addr(alu_res), .wdata(rs2_val), .rdata(dmem_rdata)
    );

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = rs1_val == rs2_val;
            3'b001:  br_taken = rs1_val != rs2_val;
            3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  br_taken = rs1_val < rs2_val;
            default: br_taken = rs1_val >= rs2_val;
        endcase
    end

    assign pc_plus4 = inst_addr + 32'd4;

    always_comb begin
        wb_data = alu_res;
        case (ctrl.wb_sel)
            WB_MEM:  wb_data = dmem_rdata;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_res;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        if (ctrl.jal || (ctrl.branch && br_taken)) next_pc = inst_addr + imm;
        else if (ctrl.jalr)                        next_pc = alu_res & ~32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) inst_addr <= RESET_PC;
        else       inst_addr <= next_pc;
    end
endmodule

// File: tb/tb_riscv_lite_cpu.sv
// Directed programs loaded into the core's memories; checks PC trace, registers and data banks.
module tb_riscv_lite_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    riscv_lite_cpu dut (.clk_i(clk), .rst_i(rst));

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        step(1);
        for (int i = 0; i < 1024; i++) dut.INST_MEM.CELL[0].CELL.mem[i] = 32'h0000_0013;
    endtask

    task automatic release_reset();
        step(5);
        rst = 1'b0;
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dut.INST_MEM.CELL[0].CELL.mem[idx] = w;
    endtask

    task automatic test_reset();
        hold_reset();
        release_reset();
        tests++;
        if (dut.inst_addr !== 32'h0040_0000) begin
            failed++; $display("FAIL reset_pc got %h want %h", dut.inst_addr, 32'h0040_0000);
        end
        for (int r = 0; r < 32; r++) begin
            tests++;
            if (dut.Registers.registers[r] !== 32'h0) begin
                failed++; $display("FAIL reset_x%0d got %h want 0", r, dut.Registers.registers[r]);
            end
        end
        step(1);
        tests++;
        if (dut.inst_addr !== 32'h0040_0004) begin
            failed++; $display("FAIL reset_pc_next got %h want %h", dut.inst_addr, 32'h0040_0004);
        end
    endtask

    task automatic test_arith();
        int          ridx [8];
        logic [31:0] rexp [8];
        hold_reset();
        put(0, 32'hFFD0_0293);   // ADDI x5,x0,-3
        put(1, 32'h0070_0313);   // ADDI x6,x0,7
        put(2, 32'h0062_83B3);   // ADD  x7,x5,x6
        put(3, 32'h4062_8433);   // SUB  x8,x5,x6
        put(4, 32'h4012_D613);   // SRAI x12,x5,1
        put(5, 32'h0062_A6B3);   // SLT  x13,x5,x6
        put(6, 32'h0062_B733);   // SLTU x14,x5,x6
        put(7, 32'h0062_C7B3);   // XOR  x15,x5,x6
        put(8, 32'h0050_0013);   // ADDI x0,x0,5
        put(9, 32'hFFFF_FFFF);   // illegal
        release_reset();
        step(10);
        ridx = '{5, 7, 8, 12, 13, 14, 15, 0};
        rexp = '{32'hFFFF_FFFD, 32'h4, 32'hFFFF_FFF6, 32'hFFFF_FFFE,
                 32'h1, 32'h0, 32'hFFFF_FFFA, 32'h0};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (dut.Registers.registers[ridx[i]] !== rexp[i]) begin
                failed++;
                $display("FAIL arith_x%0d got %h want %h", ridx[i], dut.Registers.registers[ridx[i]], rexp[i]);
            end
        end
        tests++;
        if (dut.inst_addr !== 32'h0040_0028) begin
            failed++; $display("FAIL arith_pc got %h want %h", dut.inst_addr, 32'h0040_0028);
        end
    endtask

    task automatic test_mem();
        hold_reset();
        dut.DATA_MEM.CELL_0.mem[0] = 32'hA5A5_A5A5;
        dut.DATA_MEM.CELL_0.mem[1] = 32'h1234_5678;
        dut.DATA_MEM.CELL_1.mem[0] = 32'h0;
        put(0, 32'h1001_0537);   // LUI  x10,0x10010
        put(1, 32'h0045_2583);   // LW   x11,4(x10)
        put(2, 32'h4005_0A13);   // ADDI x20,x10,1024
        put(3, 32'h40BA_2023);   // SW   x11,1024(x20)
        put(4, 32'h400A_2B03);   // LW   x22,1024(x20)
        put(5, 32'hFFC5_2583);   // LW   x11,-4(x10)  out of range
        release_reset();
        step(2);
        tests++;
        if (dut.Registers.registers[11] !== 32'h1234_5678) begin
            failed++; $display("FAIL lw_x11 got %h want %h", dut.Registers.registers[11], 32'h1234_5678);
        end
        tests++;
        if (dut.Registers.registers[10] !== 32'h1001_0000) begin
            failed++; $display("FAIL lui_x10 got %h want %h", dut.Registers.registers[10], 32'h1001_0000);
        end
        step(4);
        tests++;
        if (dut.DATA_MEM.CELL_1.mem[0] !== 32'h1234_5678) begin
            failed++; $display("FAIL sw_bank1 got %h want %h", dut.DATA_MEM.CELL_1.mem[0], 32'h1234_5678);
        end
        tests++;
        if (dut.DATA_MEM.CELL_0.mem[0] !== 32'hA5A5_A5A5) begin
            failed++; $display("FAIL bank0_untouched got %h want %h", dut.DATA_MEM.CELL_0.mem[0], 32'hA5A5_A5A5);
        end
        tests++;
        if (dut.Registers.registers[22] !== 32'h1234_5678) begin
            failed++; $display("FAIL lw_bank1 got %h want %h", dut.Registers.registers[22], 32'h1234_5678);
        end
        tests++;
        if (dut.Registers.registers[11] !== 32'h0) begin
            failed++; $display("FAIL lw_oor got %h want 0", dut.Registers.registers[11]);
        end
    endtask

    task automatic test_branch();
        logic [31:0] pexp [7];
        hold_reset();
        put(0, 32'h0000_0463);   // BEQ  x0,x0,+8
        put(2, 32'h0000_1463);   // BNE  x0,x0,+8
        put(3, 32'hFFF0_0293);   // ADDI x5,x0,-1
        put(4, 32'h0010_0313);   // ADDI x6,x0,1
        put(5, 32'h0062_C463);   // BLT  x5,x6,+8
        put(7, 32'h0062_E463);   // BLTU x5,x6,+8
        put(8, 32'hFE62_F0E3);   // BGEU x5,x6,-32
        release_reset();
        pexp = '{32'h0040_0008, 32'h0040_000C, 32'h0040_0010, 32'h0040_0014,
                 32'h0040_001C, 32'h0040_0020, 32'h0040_0000};
        for (int i = 0; i < 7; i++) begin
            step(1);
            tests++;
            if (dut.inst_addr !== pexp[i]) begin
                failed++; $display("FAIL branch_pc%0d got %h want %h", i, dut.inst_addr, pexp[i]);
            end
        end
    endtask

    task automatic test_jump();
        hold_reset();
        put(0, 32'h0000_1197);   // AUIPC x3,0x1
        put(4, 32'h00C0_00EF);   // JAL   x1,+12
        put(5, 32'h0010_8167);   // JALR  x2,1(x1)
        put(7, 32'h0000_8067);   // RET
        release_reset();
        step(5);
        tests++;
        if (dut.inst_addr !== 32'h0040_001C) begin
            failed++; $display("FAIL jal_pc got %h want %h", dut.inst_addr, 32'h0040_001C);
        end
        tests++;
        if (dut.Registers.registers[1] !== 32'h0040_0014) begin
            failed++; $display("FAIL jal_link got %h want %h", dut.Registers.registers[1], 32'h0040_0014);
        end
        tests++;
        if (dut.Registers.registers[3] !== 32'h0040_1000) begin
            failed++; $display("FAIL auipc got %h want %h", dut.Registers.registers[3], 32'h0040_1000);
        end
        step(1);
        tests++;
        if (dut.inst_addr !== 32'h0040_0014) begin
            failed++; $display("FAIL ret_pc got %h want %h", dut.inst_addr, 32'h0040_0014);
        end
        step(1);
        tests++;
        if (dut.inst_addr !== 32'h0040_0014) begin
            failed++; $display("FAIL jalr_lsb_pc got %h want %h", dut.inst_addr, 32'h0040_0014);
        end
        tests++;
        if (dut.Registers.registers[2] !== 32'h0040_0018) begin
            failed++; $display("FAIL jalr_link got %h want %h", dut.Registers.registers[2], 32'h0040_0018);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mem();
        test_branch();
        test_jump();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
